// File: rtl/bullet_pool_scheduler.sv
// Purpose: shares a pool of NUM_SLOTS bullet entities among NUM_PLAYERS tanks,
//          with round-robin arbitration, a per-player cooldown and a per-player
//          live-bullet cap.
// Latency: 1 frame, from fireReq sampled at an edge to slotSpawn/fireAck high
//          for the following frame. liveCount is combinational from registers.
// Backpressure: none is queued. A blocked or refused request is simply
//          re-evaluated every frame while the caller keeps fireReq high.
//
// Ports:
//   frameClk, reset            clock (one edge per frame); sync active-high reset
//   fireReq[p]                 level fire request per player
//   fireX/fireY[32p+:32]       spawn position per player
//   fireDir[p]                 spawn direction per player
//   slotExists[i]              bulletExists fed back from each entity
//   slotSpawn[i]               one-hot, one-frame sigSpawn pulse to the chosen entity
//   spawnX/spawnY/spawnDir     spawn parameters for the pulsed slot (held when idle)
//   fireAck[p]                 one-hot, one-frame grant pulse to the winning player
//   liveCount[4p+:4]           busy slots owned by player p

package bulletPoolPkg;
    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        DOWN  = 2'd3
    } DIRECTION;
endpackage

module bullet_pool_scheduler
    import bulletPoolPkg::*;
#(
    parameter int NUM_SLOTS      = 8,
    parameter int NUM_PLAYERS    = 2,
    parameter int MAX_PER_PLAYER = 4,
    parameter int COOLDOWN       = 15
) (
    input  logic                     frameClk,
    input  logic                     reset,
    input  logic [NUM_PLAYERS-1:0]   fireReq,
    input  logic [NUM_PLAYERS*32-1:0] fireX,
    input  logic [NUM_PLAYERS*32-1:0] fireY,
    input  DIRECTION                 fireDir [NUM_PLAYERS],
    input  logic [NUM_SLOTS-1:0]     slotExists,
    output logic [NUM_SLOTS-1:0]     slotSpawn,
    output logic [31:0]              spawnX,
    output logic [31:0]              spawnY,
    output DIRECTION                 spawnDir,
    output logic [NUM_PLAYERS-1:0]   fireAck,
    output logic [NUM_PLAYERS*4-1:0] liveCount
);

    logic [1:0]           owner [NUM_SLOTS];
    logic [7:0]           cd    [NUM_PLAYERS];
    logic [1:0]           rrPtr;

    logic [NUM_SLOTS-1:0] busy;
    logic [5:0]           ownedCnt [NUM_PLAYERS];
    logic [3:0]           eligPad;
    logic                 freeVld;
    logic [4:0]           freeIdx;
    logic                 winVld;
    logic                 grantVld;
    logic [1:0]           grantIdx;
    logic [31:0]          selX;
    logic [31:0]          selY;
    DIRECTION             selDir;

    // A slot whose spawn pulse is in flight counts as busy: the entity only
    // raises bulletExists a frame later, and this is what prevents a double spawn.
    always_comb begin
        busy = slotExists | slotSpawn;
    end

    // Lowest free slot: descending scan so the smallest index is written last.
    always_comb begin
        freeVld = 1'b0;
        freeIdx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                freeVld = 1'b1;
                freeIdx = 5'(i);
            end
        end
    end

    // Per-player ownership counts and eligibility. The internal count is wide
    // enough for the whole pool; the 4-bit output saturates.
    always_comb begin
        eligPad = '0;
        liveCount = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            ownedCnt[p] = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (busy[i] && owner[i] == 2'(p)) begin
                    ownedCnt[p] = ownedCnt[p] + 6'd1;
                end
            end
            eligPad[p] = fireReq[p] && (cd[p] == 8'd0) &&
                         (ownedCnt[p] < 6'(MAX_PER_PLAYER));
            liveCount[p*4 +: 4] = (ownedCnt[p] > 6'd15) ? 4'hF : ownedCnt[p][3:0];
        end
    end

    // Round-robin: search rrPtr+1, rrPtr+2, ... The loop runs backwards so the
    // closest eligible player overwrites any further one.
    always_comb begin
        winVld   = 1'b0;
        grantIdx = '0;
        for (int k = NUM_PLAYERS; k >= 1; k--) begin
            if (eligPad[2'((int'(rrPtr) + k) % NUM_PLAYERS)]) begin
                winVld   = 1'b1;
                grantIdx = 2'((int'(rrPtr) + k) % NUM_PLAYERS);
            end
        end
        grantVld = winVld && freeVld;
    end

    always_comb begin
        selX   = '0;
        selY   = '0;
        selDir = RIGHT;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (grantIdx == 2'(p)) begin
                selX   = fireX[p*32 +: 32];
                selY   = fireY[p*32 +: 32];
                selDir = fireDir[p];
            end
        end
    end

    always_ff @(posedge frameClk) begin
        if (reset) begin
            slotSpawn <= '0;
            fireAck   <= '0;
            spawnX    <= '0;
            spawnY    <= '0;
            spawnDir  <= RIGHT;
            rrPtr     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                owner[i] <= '0;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                cd[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                fireAck[p] <= grantVld && (grantIdx == 2'(p));
                if (grantVld && grantIdx == 2'(p)) begin
                    cd[p] <= 8'(COOLDOWN);
                end else if (cd[p] != 8'd0) begin
                    cd[p] <= cd[p] - 8'd1;
                end
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slotSpawn[i] <= grantVld && (freeIdx == 5'(i));
                if (grantVld && freeIdx == 5'(i)) begin
                    owner[i] <= grantIdx;
                end
            end
            if (grantVld) begin
                spawnX   <= selX;
                spawnY   <= selY;
                spawnDir <= selDir;
                rrPtr    <= grantIdx;
            end
        end
    end

endmodule

// File: tb/tb_bullet_pool_scheduler.sv
// Purpose: checks bullet_pool_scheduler with COOLDOWN=15 (instance A) and
//          COOLDOWN=0 (instance B) sharing one stimulus stream.
// Each vector names which instance it checks; its expectations are queued
// when the vector is driven and compared #1 after the following edge.
module tb_bullet_pool_scheduler;
    import bulletPoolPkg::*;

    typedef struct {
        bit        dutB;
        bit        rst;
        logic [1:0] req;
        logic [7:0] ex;
        logic [7:0] expSpawn;
        logic [1:0] expAck;
        logic [31:0] expX;
        DIRECTION  expDir;
        logic [3:0] expL0;
        logic [3:0] expL1;
    } vec_t;

    logic        frameClk;
    logic        reset;
    logic [1:0]  fireReq;
    logic [63:0] fireX;
    logic [63:0] fireY;
    DIRECTION    fireDir [2];
    logic [7:0]  slotExists;

    logic [7:0]  spawnA, spawnB;
    logic [31:0] xA, xB, yA, yB;
    DIRECTION    dirA, dirB;
    logic [1:0]  ackA, ackB;
    logic [7:0]  liveA, liveB;

    int checks = 0;
    int errors = 0;
    int rowNum = 0;
    vec_t vecs[$];
    vec_t sb[$];

    bullet_pool_scheduler #(.NUM_SLOTS(8), .NUM_PLAYERS(2), .MAX_PER_PLAYER(4), .COOLDOWN(15)) dutA (
        .frameClk(frameClk), .reset(reset), .fireReq(fireReq), .fireX(fireX), .fireY(fireY),
        .fireDir(fireDir), .slotExists(slotExists), .slotSpawn(spawnA), .spawnX(xA), .spawnY(yA),
        .spawnDir(dirA), .fireAck(ackA), .liveCount(liveA));

    bullet_pool_scheduler #(.NUM_SLOTS(8), .NUM_PLAYERS(2), .MAX_PER_PLAYER(4), .COOLDOWN(0)) dutB (
        .frameClk(frameClk), .reset(reset), .fireReq(fireReq), .fireX(fireX), .fireY(fireY),
        .fireDir(fireDir), .slotExists(slotExists), .slotSpawn(spawnB), .spawnX(xB), .spawnY(yB),
        .spawnDir(dirB), .fireAck(ackB), .liveCount(liveB));

    initial frameClk = 1'b0;
    always #5 frameClk = ~frameClk;

    function automatic vec_t mk(bit b, bit r, logic [1:0] q, logic [7:0] e, logic [7:0] sp,
                                logic [1:0] ak, logic [31:0] x, DIRECTION d,
                                logic [3:0] l0, logic [3:0] l1);
        vec_t v;
        v.dutB = b; v.rst = r; v.req = q; v.ex = e; v.expSpawn = sp; v.expAck = ak;
        v.expX = x; v.expDir = d; v.expL0 = l0; v.expL1 = l1;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, rowNum, act, exp);
        end
    endtask

    task automatic checkOut();
        vec_t e;
        logic [31:0] expY;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard row %0d: got empty queue, expected an entry", rowNum);
            return;
        end
        e = sb.pop_front();
        // Player 0 spawns at (100,50), player 1 at (200,75).
        expY = (e.expX == 32'd100) ? 32'd50 : (e.expX == 32'd200) ? 32'd75 : 32'd0;
        if (e.dutB) begin
            cmp("B.slotSpawn", 32'(spawnB), 32'(e.expSpawn));
            cmp("B.fireAck",   32'(ackB),   32'(e.expAck));
            cmp("B.spawnX",    xB,          e.expX);
            cmp("B.spawnY",    yB,          expY);
            cmp("B.spawnDir",  32'(dirB),   32'(e.expDir));
            cmp("B.liveCount0", 32'(liveB[3:0]), 32'(e.expL0));
            cmp("B.liveCount1", 32'(liveB[7:4]), 32'(e.expL1));
        end else begin
            cmp("A.slotSpawn", 32'(spawnA), 32'(e.expSpawn));
            cmp("A.fireAck",   32'(ackA),   32'(e.expAck));
            cmp("A.spawnX",    xA,          e.expX);
            cmp("A.spawnY",    yA,          expY);
            cmp("A.spawnDir",  32'(dirA),   32'(e.expDir));
            cmp("A.liveCount0", 32'(liveA[3:0]), 32'(e.expL0));
            cmp("A.liveCount1", 32'(liveA[7:4]), 32'(e.expL1));
        end
    endtask

    initial begin
        reset      = 1'b1;
        fireReq    = '0;
        slotExists = '0;
        fireX      = {32'd200, 32'd100};
        fireY      = {32'd75, 32'd50};
        fireDir[0] = UP;
        fireDir[1] = LEFT;

        // Instance A (COOLDOWN=15): single fire, round-robin start, full pool, reset after grant.
        vecs.push_back(mk(0, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   RIGHT, 0, 0));
        vecs.push_back(mk(0, 0, 2'b01, 8'h00, 8'h01, 2'b01, 100, UP,    1, 0));
        vecs.push_back(mk(0, 0, 2'b00, 8'h01, 8'h00, 2'b00, 100, UP,    1, 0));
        vecs.push_back(mk(0, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   RIGHT, 0, 0));
        vecs.push_back(mk(0, 0, 2'b11, 8'h00, 8'h01, 2'b10, 200, LEFT,  0, 1));
        vecs.push_back(mk(0, 0, 2'b11, 8'h01, 8'h02, 2'b01, 100, UP,    1, 1));
        vecs.push_back(mk(0, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   RIGHT, 0, 0));
        vecs.push_back(mk(0, 0, 2'b11, 8'hFF, 8'h00, 2'b00, 0,   RIGHT, 8, 0));
        vecs.push_back(mk(0, 0, 2'b11, 8'hDF, 8'h20, 2'b10, 200, LEFT,  7, 1));
        vecs.push_back(mk(0, 0, 2'b11, 8'hDF, 8'h00, 2'b00, 200, LEFT,  7, 0));
        vecs.push_back(mk(0, 0, 2'b00, 8'hFF, 8'h00, 2'b00, 200, LEFT,  7, 1));
        vecs.push_back(mk(0, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   RIGHT, 0, 0));
        vecs.push_back(mk(0, 0, 2'b01, 8'h00, 8'h01, 2'b01, 100, UP,    1, 0));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 8'h00, 2'b00, 0,   RIGHT, 0, 0));
        vecs.push_back(mk(0, 0, 2'b01, 8'h00, 8'h01, 2'b01, 100, UP,    1, 0));
        // Instance B (COOLDOWN=0): cap of 4 live bullets, then kill slot2 and reuse it.
        vecs.push_back(mk(1, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   RIGHT, 0, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h00, 8'h01, 2'b01, 100, UP,    1, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h01, 8'h02, 2'b01, 100, UP,    2, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h03, 8'h04, 2'b01, 100, UP,    3, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h07, 8'h08, 2'b01, 100, UP,    4, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h0F, 8'h00, 2'b00, 100, UP,    4, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h0F, 8'h00, 2'b00, 100, UP,    4, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h0B, 8'h04, 2'b01, 100, UP,    4, 0));
        vecs.push_back(mk(1, 0, 2'b01, 8'h0F, 8'h00, 2'b00, 100, UP,    4, 0));
        // Instance A: held request, grants only every 16th frame (frames 1, 17, 33).
        vecs.push_back(mk(0, 1, 2'b00, 8'h00, 8'h00, 2'b00, 0,   RIGHT, 0, 0));
        for (int f = 1; f <= 40; f++) begin
            bit g;
            g = ((f - 1) % 16) == 0;
            vecs.push_back(mk(0, 0, 2'b01, 8'h00, g ? 8'h01 : 8'h00, g ? 2'b01 : 2'b00,
                              100, UP, g ? 4'd1 : 4'd0, 0));
        end

        for (int r = 0; r < vecs.size(); r++) begin
            rowNum     = r;
            reset      = vecs[r].rst;
            fireReq    = vecs[r].req;
            slotExists = vecs[r].ex;
            sb.push_back(vecs[r]);
            @(posedge frameClk);
            #1;
            checkOut();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
